// File: rtl/pd_power_sequencer.sv
// Power-domain sequencer: drives the header SLEEP chain, isolation clamps and
// level-shifter ISOLN in isolate -> switch-off -> switch-on -> settle -> de-isolate order.
module pd_power_sequencer #(
  parameter int ISO_SETUP   = 4,
  parameter int PWR_SETTLE  = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int CW          = 8
) (
  input  logic CK,
  input  logic RST,
  input  logic PWR_REQ,
  input  logic ERR_CLR,
  input  logic SLEEPOUT_ACK,
  output logic SLEEP,
  output logic ISO_EN,
  output logic ISOLN,
  output logic PWR_ON,
  output logic BUSY,
  output logic ERR
);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    SWITCH_ON  = 3'd1,
    SETTLE     = 3'd2,
    ON         = 3'd3,
    ISOLATE    = 3'd4,
    SWITCH_OFF = 3'd5,
    ERR_ST     = 3'd6
  } state_t;

  // The counter holds (cycles spent in the current state - 1), so each
  // duration is reached one count early and the exit lands on the Nth edge.
  localparam logic [CW-1:0] ISO_LAST    = CW'(ISO_SETUP - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(PWR_SETTLE - 1);
  localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          ack_meta;
  logic          ack_s;
  logic          ack_late;
  logic          sleep_d;
  logic          iso_d;
  logic          pwr_on_d;
  logic          busy_d;
  logic          err_d;

  // Synchroniser: idles high, matching a header chain that is switched off.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      ack_meta <= 1'b1;
      ack_s    <= 1'b1;
    end else begin
      ack_meta <= SLEEPOUT_ACK;
      ack_s    <= ack_meta;
    end
  end

  assign ack_late = (cnt >= ACK_LAST);

  always_comb begin
    state_next = state;
    case (state)
      OFF:        if (PWR_REQ) state_next = SWITCH_ON;
      SWITCH_ON: begin
        if (!ack_s)        state_next = SETTLE;
        else if (ack_late) state_next = ERR_ST;
      end
      SETTLE:     if (cnt >= SETTLE_LAST) state_next = ON;
      ON:         if (!PWR_REQ) state_next = ISOLATE;
      ISOLATE:    if (cnt >= ISO_LAST) state_next = SWITCH_OFF;
      SWITCH_OFF: begin
        if (ack_s)         state_next = OFF;
        else if (ack_late) state_next = ERR_ST;
      end
      ERR_ST:     if (ERR_CLR) state_next = OFF;
      default:    state_next = OFF;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state and never glitch.
  always_comb begin
    sleep_d  = 1'b1;
    iso_d    = 1'b1;
    pwr_on_d = 1'b0;
    busy_d   = 1'b0;
    err_d    = 1'b0;
    case (state_next)
      SWITCH_ON, SETTLE, ISOLATE: begin
        sleep_d = 1'b0;
        busy_d  = 1'b1;
      end
      ON: begin
        sleep_d  = 1'b0;
        iso_d    = 1'b0;
        pwr_on_d = 1'b1;
      end
      SWITCH_OFF: busy_d = 1'b1;
      ERR_ST:     err_d  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      SLEEP  <= 1'b1;
      ISO_EN <= 1'b1;
      ISOLN  <= 1'b0;
      PWR_ON <= 1'b0;
      BUSY   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      SLEEP  <= sleep_d;
      ISO_EN <= iso_d;
      ISOLN  <= ~iso_d;
      PWR_ON <= pwr_on_d;
      BUSY   <= busy_d;
      ERR    <= err_d;
    end
  end

  a_isoln_inverse: assert property (@(posedge CK) disable iff (RST) ISOLN == ~ISO_EN);
  a_sleep_isolated: assert property (@(posedge CK) disable iff (RST) !(SLEEP && !ISO_EN));

endmodule

// File: tb/tb_pd_power_sequencer.sv
// Directed bench for pd_power_sequencer with an elapsed-time phase model checked every cycle.
module tb_pd_power_sequencer;

  localparam int ISO_SETUP   = 4;
  localparam int PWR_SETTLE  = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int CW          = 8;

  localparam int P_OFF = 0, P_UP = 1, P_SETTLE = 2, P_ON = 3, P_ISO = 4, P_DOWN = 5, P_ERR = 6;

  logic CK = 1'b0;
  logic RST = 1'b0;
  logic PWR_REQ = 1'b0;
  logic ERR_CLR = 1'b0;
  logic SLEEPOUT_ACK = 1'b1;
  logic SLEEP, ISO_EN, ISOLN, PWR_ON, BUSY, ERR;

  logic clk_en = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n;

  // Header emulation: SLEEPOUT follows SLEEP after hdr_dly observed cycles.
  logic [15:0] sleep_hist = '1;
  int hdr_dly = 3;
  logic hdr_auto = 1'b1;

  // Model state: phase plus the edge number at which it was entered.
  int m_phase = P_OFF;
  int m_edge = 0;
  int m_since = 0;
  int m_next;
  logic m_a1 = 1'b1;
  logic m_a2 = 1'b1;

  pd_power_sequencer #(
    .ISO_SETUP(ISO_SETUP), .PWR_SETTLE(PWR_SETTLE), .ACK_TIMEOUT(ACK_TIMEOUT), .CW(CW)
  ) dut (
    .CK(CK), .RST(RST), .PWR_REQ(PWR_REQ), .ERR_CLR(ERR_CLR), .SLEEPOUT_ACK(SLEEPOUT_ACK),
    .SLEEP(SLEEP), .ISO_EN(ISO_EN), .ISOLN(ISOLN), .PWR_ON(PWR_ON), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 if (clk_en) CK = ~CK;

  function automatic int model_next(input int ph, input int elapsed, input logic acks,
                                    input logic req, input logic clr);
    int r;
    r = ph;
    case (ph)
      P_OFF:    if (req) r = P_UP;
      P_UP:     if (!acks) r = P_SETTLE; else if (elapsed >= ACK_TIMEOUT) r = P_ERR;
      P_SETTLE: if (elapsed >= PWR_SETTLE) r = P_ON;
      P_ON:     if (!req) r = P_ISO;
      P_ISO:    if (elapsed >= ISO_SETUP) r = P_DOWN;
      P_DOWN:   if (acks) r = P_OFF; else if (elapsed >= ACK_TIMEOUT) r = P_ERR;
      P_ERR:    if (clr) r = P_OFF;
      default:  r = P_OFF;
    endcase
    return r;
  endfunction

  always_comb m_next = model_next(m_phase, m_edge + 1 - m_since, m_a2, PWR_REQ, ERR_CLR);

  always @(posedge CK or posedge RST) begin
    if (RST) begin
      m_phase <= P_OFF;
      m_since <= m_edge;
      m_a1    <= 1'b1;
      m_a2    <= 1'b1;
    end else begin
      m_edge <= m_edge + 1;
      if (m_next != m_phase) begin
        m_phase <= m_next;
        m_since <= m_edge + 1;
      end
      m_a2 <= m_a1;
      m_a1 <= SLEEPOUT_ACK;
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic e_sleep, e_iso;
    e_sleep = (m_phase == P_OFF) || (m_phase == P_DOWN) || (m_phase == P_ERR);
    e_iso   = (m_phase != P_ON);
    chk("model_sleep", SLEEP, e_sleep);
    chk("model_iso_en", ISO_EN, e_iso);
    chk("model_isoln", ISOLN, !e_iso);
    chk("model_pwr_on", PWR_ON, m_phase == P_ON);
    chk("model_busy", BUSY, (m_phase == P_UP) || (m_phase == P_SETTLE) ||
                            (m_phase == P_ISO) || (m_phase == P_DOWN));
    chk("model_err", ERR, m_phase == P_ERR);
  endtask

  // One cycle: compare on the falling edge, then update the header feedback.
  task automatic tick();
    @(negedge CK);
    cyc++;
    if (!RST) cmp_model();
    sleep_hist = {sleep_hist[14:0], SLEEP};
    if (hdr_auto) SLEEPOUT_ACK = sleep_hist[hdr_dly-1];
  endtask

  task automatic run_until_on(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!PWR_ON && cnt < 200);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the clock stopped
    #1 RST = 1'b1;
    #1;
    chk("rst_sleep", SLEEP, 1'b1);
    chk("rst_iso_en", ISO_EN, 1'b1);
    chk("rst_isoln", ISOLN, 1'b0);
    chk("rst_pwr_on", PWR_ON, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_err", ERR, 1'b0);
    clk_en = 1'b1;
    tick();
    RST = 1'b0;
    repeat (20) tick();
    chk("idle_sleep", SLEEP, 1'b1);
    chk("idle_busy", BUSY, 1'b0);

    // Power-up with acknowledge 3 cycles after SLEEP falls
    hdr_dly = 3;
    PWR_REQ = 1'b1;
    tick();
    chk("pu_sleep_low", SLEEP, 1'b0);
    chk("pu_iso_held", ISO_EN, 1'b1);
    n = 1;
    while (!PWR_ON && n < 200) begin
      tick();
      n++;
    end
    chk_int("pu_latency", n, 14);

    // Power-down with acknowledge 2 cycles after SLEEP rises
    hdr_dly = 2;
    PWR_REQ = 1'b0;
    tick();
    chk("pd_iso_en", ISO_EN, 1'b1);
    chk("pd_pwr_on", PWR_ON, 1'b0);
    chk("pd_sleep_still_low", SLEEP, 1'b0);
    n = 1;
    while (!SLEEP && n < 200) begin
      tick();
      n++;
    end
    chk_int("pd_sleep_latency", n, 1 + ISO_SETUP);
    while (BUSY && n < 200) begin
      tick();
      n++;
    end
    chk_int("pd_off_latency", n, 9);
    chk("pd_off_sleep", SLEEP, 1'b1);
    repeat (5) tick();

    // ERR_CLR while ON is ignored
    hdr_dly = 3;
    PWR_REQ = 1'b1;
    run_until_on(n);
    chk_int("pu2_latency", n, 14);
    repeat (2) tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    tick();
    chk("clr_in_on_pwr_on", PWR_ON, 1'b1);
    chk("clr_in_on_err", ERR, 1'b0);

    // Timeout in SWITCH_OFF with the acknowledge stuck low
    hdr_auto = 1'b0;
    SLEEPOUT_ACK = 1'b0;
    PWR_REQ = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ERR && n < 200);
    chk_int("timeout_latency", n, 1 + ISO_SETUP + ACK_TIMEOUT);
    chk("timeout_sleep", SLEEP, 1'b1);
    chk("timeout_iso_en", ISO_EN, 1'b1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("errclr_err", ERR, 1'b0);
    chk("errclr_busy", BUSY, 1'b0);
    chk("errclr_sleep", SLEEP, 1'b1);
    hdr_auto = 1'b1;
    repeat (5) tick();

    // Request dropped in SWITCH_ON and restored in SETTLE
    PWR_REQ = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 2) PWR_REQ = 1'b0;
      if (n == 8) PWR_REQ = 1'b1;
    end while (!PWR_ON && n < 200);
    chk_int("toggle_latency", n, 14);
    repeat (3) tick();
    chk("toggle_stays_on", PWR_ON, 1'b1);

    PWR_REQ = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while ((BUSY || PWR_ON) && n < 200);
    repeat (3) tick();

    // Request dropped in SETTLE and left low: one ON cycle, then ISOLATE
    PWR_REQ = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 8) PWR_REQ = 1'b0;
    end while (!PWR_ON && n < 200);
    chk_int("drop_settle_latency", n, 14);
    tick();
    chk("drop_settle_pwr_on", PWR_ON, 1'b0);
    chk("drop_settle_iso_en", ISO_EN, 1'b1);
    chk("drop_settle_busy", BUSY, 1'b1);
    n = 0;
    do begin
      tick();
      n++;
    end while (BUSY && n < 200);
    chk("drop_settle_off", SLEEP, 1'b1);
    repeat (3) tick();

    // Asynchronous reset during SETTLE
    PWR_REQ = 1'b1;
    repeat (8) tick();
    chk("settle_busy", BUSY, 1'b1);
    chk("settle_sleep", SLEEP, 1'b0);
    chk("settle_iso_en", ISO_EN, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("midrst_sleep", SLEEP, 1'b1);
    chk("midrst_iso_en", ISO_EN, 1'b1);
    chk("midrst_isoln", ISOLN, 1'b0);
    chk("midrst_busy", BUSY, 1'b0);
    PWR_REQ = 1'b0;
    tick();
    RST = 1'b0;
    repeat (6) tick();
    chk("post_rst_sleep", SLEEP, 1'b1);
    chk("post_rst_busy", BUSY, 1'b0);

    // Acknowledge arrives on the same edge the timeout expires
    PWR_REQ = 1'b1;
    run_until_on(n);
    chk_int("pu3_latency", n, 14);
    hdr_auto = 1'b0;
    SLEEPOUT_ACK = 1'b0;
    PWR_REQ = 1'b0;
    repeat (66) tick();
    SLEEPOUT_ACK = 1'b1;
    tick();
    tick();
    chk("tie_pre_busy", BUSY, 1'b1);
    chk("tie_pre_err", ERR, 1'b0);
    tick();
    chk("tie_err", ERR, 1'b0);
    chk("tie_busy", BUSY, 1'b0);
    chk("tie_sleep", SLEEP, 1'b1);
    hdr_auto = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
